// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   OP_J          : primary opcode of the unconditional jump, also used by decode
//   NOP           : instruction presented when nothing valid is fetched
//   fetch_state_e : request tracking state (idle / waiting / dropping)
//   fetch_entry_t : prefetch queue entry {instruction, word address + 1}
package if_fetch_pkg;

    localparam logic [5:0]  OP_J    = 6'b000010;
    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam int          ENTRY_W = 62;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // nothing outstanding
        ST_WAIT = 2'd1,   // one request outstanding, response is kept
        ST_DROP = 2'd2    // one request outstanding, response is thrown away
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] ins;
        logic [29:0] pc_plus_1;
    } fetch_entry_t;

    function automatic logic is_jump(input logic [5:0] opcode);
        return opcode == OP_J;
    endfunction

    // Jump target keeps the 256 MB region of the instruction after the jump.
    function automatic logic [29:0] jump_target(input logic [3:0]  region,
                                                 input logic [25:0] index);
        return {region, index};
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Prefetch queue between instruction memory and the IF/ID register.
//   clk, rst   : clock, synchronous active-high reset (pointers and count only)
//   push       : write push_data (accepted when not full, or full with pop)
//   pop        : drop the head entry (ignored when empty)
//   flush      : discard all entries; dominates push and pop
//   head_data  : oldest entry (undefined when empty)
//   full/empty : occupancy flags, count : number of valid entries
module fetch_fifo
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [ENTRY_W-1:0]       head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full      = count_q == CNT_W'(DEPTH);
    assign empty     = count_q == '0;
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_pop    = pop && !empty && !flush;
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign do_push   = push && !flush && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage with a small prefetch queue and jump predecode.
//   clk, rst            : clock, synchronous active-high reset
//   stall               : hold the presented instruction (not consumed)
//   redirect/redirect_pc: taken branch from decode, flush and refetch at target
//   imem_req/imem_addr  : instruction memory request and word address
//   imem_gnt            : request accepted this cycle
//   imem_rvalid/rdata   : response for the single outstanding request
//   if_valid/if_ins     : queue head presented to IF/ID (NOP when empty)
//   if_pc_plus_4        : word address + 1 of the presented instruction
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [29:0] RESET_PC = 30'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [29:0] redirect_pc,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_ins,
    output logic [29:0] if_pc_plus_4
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e       state_q, state_d;
    logic [29:0]        fetch_pc_q, fetch_pc_d;
    logic [29:0]        last_pc_q, last_pc_d;
    // Set when reset hit with a request in flight: its response must be eaten.
    logic               discard_q, discard_d;

    fetch_entry_t       head, push_entry;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               push, pop, rsp_take, rsp_jump, room_after, gnt_ok;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign imem_addr    = fetch_pc_q;
    assign if_valid     = !fifo_empty;
    assign if_ins       = fifo_empty ? NOP : head.ins;
    assign if_pc_plus_4 = fifo_empty ? last_pc_q : head.pc_plus_1;

    always_comb begin
        pop        = !fifo_empty && !stall && !redirect;
        rsp_take   = (state_q == ST_WAIT) && imem_rvalid && !redirect;
        rsp_jump   = rsp_take && is_jump(imem_rdata[31:26]);
        push       = rsp_take;
        // fetch_pc already points past the outstanding request.
        push_entry = '{ins: imem_rdata, pc_plus_1: fetch_pc_q};
        room_after = (int'(fifo_count) - int'(pop) + 1) < DEPTH;

        imem_req = 1'b0;
        case (state_q)
            ST_IDLE: imem_req = !discard_q && !fifo_full && !redirect;
            // Back-to-back request, suppressed after a jump so nothing younger is in flight.
            ST_WAIT: imem_req = rsp_take && !rsp_jump && room_after;
            default: imem_req = 1'b0;
        endcase
        if (rst) imem_req = 1'b0;
        gnt_ok = imem_req && imem_gnt;

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        last_pc_d  = fifo_empty ? last_pc_q : head.pc_plus_1;

        case (state_q)
            ST_IDLE: begin
                if (discard_q && imem_rvalid) discard_d = 1'b0;
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (gnt_ok) begin
                    fetch_pc_d = fetch_pc_q + 30'd1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = imem_rvalid ? ST_IDLE : ST_DROP;
                end else if (imem_rvalid) begin
                    if (rsp_jump) begin
                        fetch_pc_d = jump_target(fetch_pc_q[29:26], imem_rdata[25:0]);
                        state_d    = ST_IDLE;
                    end else if (gnt_ok) begin
                        fetch_pc_d = fetch_pc_q + 30'd1;
                        state_d    = ST_WAIT;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (redirect)    fetch_pc_d = redirect_pc;
                if (imem_rvalid) state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst) begin
            state_d    = ST_IDLE;
            fetch_pc_d = RESET_PC;
            last_pc_d  = '0;
            // Remember a response still owed by memory unless it arrives right now.
            discard_d  = ((state_q != ST_IDLE) || discard_q) && !imem_rvalid;
        end
    end

    always_ff @(posedge clk) begin
        state_q    <= state_d;
        fetch_pc_q <= fetch_pc_d;
        last_pc_q  <= last_pc_d;
        discard_q  <= discard_d;
    end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [29:0] redirect_pc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [29:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_ins;
    logic [29:0] if_pc_plus_4;

    int checks   = 0;
    int failures = 0;

    // memory model state
    int          lat;
    logic        pend;
    int          pcnt;
    logic [29:0] paddr;
    logic [9:0]  ptag, tag;
    logic        jmp_en;

    logic [29:0] got_pc[$];
    logic [31:0] got_ins[$];

    if_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_ins       (if_ins),
        .if_pc_plus_4 (if_pc_plus_4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mword(input logic [29:0] a, input logic [9:0] t);
        if (jmp_en && a == 30'd5) return 32'h0800_0010;
        return {6'b001000, t, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] qpc(input int i);
        return (i < got_pc.size()) ? 64'(got_pc[i]) : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] qins(input int i);
        return (i < got_ins.size()) ? 64'(got_ins[i]) : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    // One clock: sample, edge, then memory model drives the next cycle.
    task automatic cyc();
        logic        req_s;
        logic [29:0] addr_s;
        #1;
        req_s  = imem_req;
        addr_s = imem_addr;
        if (!rst && if_valid && !stall && !redirect) begin
            got_pc.push_back(if_pc_plus_4);
            got_ins.push_back(if_ins);
        end
        @(posedge clk);
        if (imem_rvalid) pend = 1'b0;
        if (req_s && imem_gnt) begin
            pend  = 1'b1;
            paddr = addr_s;
            ptag  = tag;
            pcnt  = lat - 1;
        end
        #1;
        if (pend && pcnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mword(paddr, ptag);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
            if (pend) pcnt = pcnt - 1;
        end
    endtask

    task automatic do_reset(input int lat_i);
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (4) cyc();
        lat = lat_i;
        got_pc.delete();
        got_ins.delete();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        lat = 1; pend = 1'b0; pcnt = 0; paddr = '0; ptag = '0; tag = '0; jmp_en = 1'b0;

        // reset state and sequential fetch, 1-cycle latency
        repeat (3) cyc();
        #1;
        chk("rst_req",   imem_req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_ins",   if_ins, 0);
        chk("rst_pc",    if_pc_plus_4, 0);
        cyc();
        rst = 1'b0;
        got_pc.delete(); got_ins.delete();
        #1;
        chk("seq_req_c0",   {imem_req, imem_addr}, {1'b1, 30'd0});
        chk("seq_valid_c0", if_valid, 0);
        cyc(); #1;
        chk("seq_req_c1",   {imem_req, imem_addr}, {1'b1, 30'd1});
        chk("seq_valid_c1", if_valid, 0);
        cyc(); #1;
        chk("seq_valid_c2", if_valid, 1);
        chk("seq_pc_c2",    if_pc_plus_4, 30'd1);
        chk("seq_ins_c2",   if_ins, 32'h2000_0000);
        cyc(); #1;
        chk("seq_pc_c3",    if_pc_plus_4, 30'd2);
        chk("seq_ins_c3",   if_ins, 32'h2000_0001);
        cyc(); #1;
        chk("seq_pc_c4",    if_pc_plus_4, 30'd3);
        cyc();

        // stall until the queue fills, then drain in order
        do_reset(1);
        stall = 1'b1;
        repeat (3) cyc();
        #1; chk("stall_req_c3", imem_req, 1);
        cyc();
        #1; chk("stall_req_c4", imem_req, 0);
        cyc();
        #1;
        chk("stall_req_full", imem_req, 0);
        chk("stall_valid",    if_valid, 1);
        chk("stall_head_pc",  if_pc_plus_4, 30'd1);
        cyc();
        stall = 1'b0;
        repeat (10) cyc();
        for (int i = 0; i < 6; i++) chk($sformatf("stall_seq%0d", i), qpc(i), 64'(i + 1));
        chk("stall_ins3", qins(3), 32'h2000_0003);

        // redirect with a request outstanding, 3-cycle latency
        do_reset(3);
        #1; chk("redir_req_c0", {imem_req, imem_addr}, {1'b1, 30'd0});
        cyc();
        redirect = 1'b1; redirect_pc = 30'h40;
        #1; chk("redir_req_c1", imem_req, 0);
        cyc();
        redirect = 1'b0;
        #1; chk("redir_drop_req", imem_req, 0);
        cyc();
        #1;
        chk("redir_stale_req",   imem_req, 0);
        chk("redir_stale_valid", if_valid, 0);
        cyc();
        #1; chk("redir_refetch", {imem_req, imem_addr}, {1'b1, 30'h40});
        repeat (8) cyc();
        chk("redir_first_pc",  qpc(0), 30'h41);
        chk("redir_first_ins", qins(0), 32'h2000_0040);

        // jump predecode at address 5
        jmp_en = 1'b1;
        do_reset(1);
        repeat (16) cyc();
        for (int i = 0; i < 6; i++) chk($sformatf("jmp_seq%0d", i), qpc(i), 64'(i + 1));
        chk("jmp_ins",     qins(5), 32'h0800_0010);
        chk("jmp_tgt_pc",  qpc(6), 30'h11);
        chk("jmp_tgt_ins", qins(6), 32'h2000_0010);
        chk("jmp_tgt_pc2", qpc(7), 30'h12);
        jmp_en = 1'b0;

        // redirect and stall together on a full queue
        do_reset(1);
        stall = 1'b1;
        repeat (6) cyc();
        redirect = 1'b1; redirect_pc = 30'h80;
        #1; chk("rs_full_valid", if_valid, 1);
        cyc();
        redirect = 1'b0; stall = 1'b0;
        #1;
        chk("rs_valid",  if_valid, 0);
        chk("rs_ins",    if_ins, 32'h0);
        chk("rs_pchold", if_pc_plus_4, 30'd1);
        chk("rs_req",    {imem_req, imem_addr}, {1'b1, 30'h80});
        repeat (6) cyc();
        chk("rs_first_pc", qpc(0), 30'h81);

        // reset while waiting; the late response must be dropped
        do_reset(2);
        tag = 10'h3;
        #1; chk("rw_req_c0", {imem_req, imem_addr}, {1'b1, 30'd0});
        cyc();
        tag = 10'h5;
        rst = 1'b1;
        #1; chk("rw_req_rst", imem_req, 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("rw_req_discard", imem_req, 0);
        chk("rw_valid",       if_valid, 0);
        cyc();
        #1; chk("rw_refetch", {imem_req, imem_addr}, {1'b1, 30'd0});
        repeat (6) cyc();
        chk("rw_first_ins", qins(0), 32'h2005_0000);
        chk("rw_first_pc",  qpc(0), 30'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
